// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multicycle CPU control unit: state encodings,
// opcodes, ALU/PC-select codes, the control-word struct and decode helpers.
package cpu_ctrl_pkg;

  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_L   = 3'b100;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_WB_AL  = 3'b111;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_RSVD = 2'b10;
  localparam logic [1:0] PCSRC_JMP  = 2'b11;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       reg_wre;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
    logic       db_data_src;
    logic       reg_dst;
    logic       m_rd;
    logic       m_wr;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  // Unknown opcodes fall through to ADD so the R-type path is taken without a trap.
  function automatic logic [2:0] alu_op_for(input logic [5:0] op);
    logic [2:0] res;
    case (op)
      OP_SUB:         res = ALU_SUB;
      OP_OR, OP_ORI:  res = ALU_OR;
      OP_AND:         res = ALU_AND;
      OP_SLT:         res = ALU_SLT;
      default:        res = ALU_ADD;
    endcase
    return res;
  endfunction

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ORI);
  endfunction

  function automatic logic br_taken(input logic [5:0] op, input logic zero);
    logic res;
    if (op == OP_BEQ) begin
      res = zero;
    end else if (op == OP_BNE) begin
      res = !zero;
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath bundle: opcode/zero from the datapath, write
// enables, mux selects and ALU operation back to it.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic [2:0] state_out;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       RegWre;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       ExtSel;
  logic       DBDataSrc;
  logic       RegDst;
  logic       mRD;
  logic       mWR;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;

  modport master (
    input  opcode, zero,
    output state_out, PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB,
           ExtSel, DBDataSrc, RegDst, mRD, mWR, PCSrc, ALUOp
  );

  modport slave (
    output opcode, zero,
    input  state_out, PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB,
           ExtSel, DBDataSrc, RegDst, mRD, mWR, PCSrc, ALUOp
  );
endinterface

// File: rtl/ctrl_decode.sv
// Moore output decode: (state, opcode, zero) -> control word. Purely
// combinational; zero only matters in the branch-execute state.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] state,
  input  logic [5:0] opcode,
  input  logic       zero,
  output ctrl_t      ctrl
);

  // Per-state control word; anything not set stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.ir_wre     = 1'b1;
        ctrl.ins_mem_rw = 1'b1;
      end
      S_ID: begin
        if (opcode == OP_J) begin
          ctrl.pc_wre = 1'b1;
          ctrl.pc_src = PCSRC_JMP;
        end else begin
          ctrl.pc_wre = 1'b0;
        end
      end
      S_EXE_AL: begin
        ctrl.alu_op    = alu_op_for(opcode);
        ctrl.alu_src_b = is_imm_alu(opcode);
        ctrl.ext_sel   = (opcode == OP_ADDI);
      end
      S_WB_AL: begin
        ctrl.reg_wre = 1'b1;
        ctrl.pc_wre  = 1'b1;
        ctrl.pc_src  = PCSRC_SEQ;
        ctrl.reg_dst = !is_imm_alu(opcode);
      end
      S_EXE_BR: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.ext_sel = 1'b1;
        ctrl.pc_wre  = 1'b1;
        if (br_taken(opcode, zero)) begin
          ctrl.pc_src = PCSRC_BR;
        end else begin
          ctrl.pc_src = PCSRC_SEQ;
        end
      end
      S_EXE_LS: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = 1'b1;
        ctrl.ext_sel   = 1'b1;
      end
      S_MEM: begin
        if (opcode == OP_LW) begin
          ctrl.m_rd = 1'b1;
        end else if (opcode == OP_SW) begin
          ctrl.m_wr   = 1'b1;
          ctrl.pc_wre = 1'b1;
          ctrl.pc_src = PCSRC_SEQ;
        end else begin
          ctrl.m_rd = 1'b0;
        end
      end
      S_WB_L: begin
        ctrl.reg_wre     = 1'b1;
        ctrl.db_data_src = 1'b1;
        ctrl.reg_dst     = 1'b0;
        ctrl.pc_wre      = 1'b1;
        ctrl.pc_src      = PCSRC_SEQ;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: state register, next-state sequencing through
// IF/ID/EXE/MEM/WB, and reset gating of the decoded control word.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic               CLK,
  input  logic               Reset,
  multicycle_ctrl_if.master  bus
);

  logic [2:0] state_r;
  logic [2:0] state_next_s;
  ctrl_t      ctrl_dec_s;
  ctrl_t      ctrl_s;

  // State register; Reset low abandons any instruction and returns to fetch.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_r <= S_IF;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state sequencing; HALT parks in decode until reset.
  always_comb begin
    state_next_s = S_IF;
    case (state_r)
      S_IF: begin
        state_next_s = S_ID;
      end
      S_ID: begin
        if (bus.opcode == OP_J) begin
          state_next_s = S_IF;
        end else if (bus.opcode == OP_HALT) begin
          state_next_s = S_ID;
        end else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)) begin
          state_next_s = S_EXE_BR;
        end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
          state_next_s = S_EXE_LS;
        end else begin
          state_next_s = S_EXE_AL;
        end
      end
      S_EXE_AL: state_next_s = S_WB_AL;
      S_WB_AL:  state_next_s = S_IF;
      S_EXE_BR: state_next_s = S_IF;
      S_EXE_LS: state_next_s = S_MEM;
      S_MEM: begin
        if (bus.opcode == OP_LW) begin
          state_next_s = S_WB_L;
        end else begin
          state_next_s = S_IF;
        end
      end
      S_WB_L:   state_next_s = S_IF;
      default:  state_next_s = S_IF;
    endcase
  end

  ctrl_decode u_decode (
    .state  (state_r),
    .opcode (bus.opcode),
    .zero   (bus.zero),
    .ctrl   (ctrl_dec_s)
  );

  // Outputs must be combinational from state so they settle before the
  // negedge captures in IR/regfile; Reset forces them low without waiting for a clock.
  always_comb begin
    if (Reset) begin
      ctrl_s = ctrl_dec_s;
    end else begin
      ctrl_s = '0;
    end
  end

  assign bus.state_out = state_r;
  assign bus.PCWre     = ctrl_s.pc_wre;
  assign bus.IRWre     = ctrl_s.ir_wre;
  assign bus.InsMemRW  = ctrl_s.ins_mem_rw;
  assign bus.RegWre    = ctrl_s.reg_wre;
  assign bus.ALUSrcA   = ctrl_s.alu_src_a;
  assign bus.ALUSrcB   = ctrl_s.alu_src_b;
  assign bus.ExtSel    = ctrl_s.ext_sel;
  assign bus.DBDataSrc = ctrl_s.db_data_src;
  assign bus.RegDst    = ctrl_s.reg_dst;
  assign bus.mRD       = ctrl_s.m_rd;
  assign bus.mWR       = ctrl_s.m_wr;
  assign bus.PCSrc     = ctrl_s.pc_src;
  assign bus.ALUOp     = ctrl_s.alu_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expectations from an
// instruction-level reference model, checked by a negedge monitor.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre, irwre, insmem, regwre, srca, srcb, ext, dbsrc, regdst, mrd, mwr;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } vec_t;

  typedef enum int {C_ALU, C_LW, C_SW, C_BR, C_J, C_HALT} cls_t;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010,
                         OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010,
                         SLT = 6'b100110, SW = 6'b110000, LW = 6'b110001,
                         BEQ = 6'b110100, BNE = 6'b110101, J = 6'b111000,
                         HALT = 6'b111111;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t exp_q[$];
  logic [5:0] ops[12] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLT, SW, LW, BEQ, BNE, J};

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t dut_vec();
    return vec_t'({bus.state_out, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.RegWre,
                   bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.DBDataSrc, bus.RegDst,
                   bus.mRD, bus.mWR, bus.PCSrc, bus.ALUOp});
  endfunction

  function automatic cls_t classify(input logic [5:0] op);
    if (op == LW) return C_LW;
    if (op == SW) return C_SW;
    if (op == BEQ || op == BNE) return C_BR;
    if (op == J) return C_J;
    if (op == HALT) return C_HALT;
    return C_ALU;
  endfunction

  function automatic int n_steps(input logic [5:0] op);
    case (classify(op))
      C_LW:    return 5;
      C_BR:    return 3;
      C_J:     return 2;
      default: return 4;
    endcase
  endfunction

  // What the instruction must show on its step-th cycle, from the state walk
  // and per-state output table of the control-unit description.
  function automatic vec_t model(input logic [5:0] op, input int step, input logic z);
    vec_t v = '0;
    cls_t c = classify(op);
    logic imm = (op == ADDI) || (op == ORI);
    if (step == 0) begin
      v.st = 3'd0; v.irwre = 1'b1; v.insmem = 1'b1;
    end else if (step == 1 || c == C_HALT) begin
      v.st = 3'd1;
      if (c == C_J) begin v.pcwre = 1'b1; v.pcsrc = 2'b11; end
    end else if (c == C_ALU) begin
      if (step == 2) begin
        v.st = 3'd6;
        v.aluop = (op == SUB) ? 3'b001 : (op == OR_ || op == ORI) ? 3'b011 :
                  (op == AND_) ? 3'b100 : (op == SLT) ? 3'b101 : 3'b000;
        v.srcb = imm; v.ext = (op == ADDI);
      end else begin
        v.st = 3'd7; v.regwre = 1'b1; v.pcwre = 1'b1; v.regdst = !imm;
      end
    end else if (c == C_BR) begin
      v.st = 3'd5; v.aluop = 3'b001; v.ext = 1'b1; v.pcwre = 1'b1;
      v.pcsrc = (((op == BEQ) && z) || ((op == BNE) && !z)) ? 2'b01 : 2'b00;
    end else if (step == 2) begin
      v.st = 3'd2; v.srcb = 1'b1; v.ext = 1'b1;
    end else if (step == 3) begin
      v.st = 3'd3;
      if (c == C_LW) v.mrd = 1'b1;
      else begin v.mwr = 1'b1; v.pcwre = 1'b1; end
    end else begin
      v.st = 3'd4; v.regwre = 1'b1; v.dbsrc = 1'b1; v.pcwre = 1'b1;
    end
    return v;
  endfunction

  task automatic check(input string name, input vec_t got, input vec_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %h required %h", name, $time, got, want);
    end
  endtask

  // Inputs change at posedge+1; the expectation for this cycle is queued.
  task automatic drive(input logic [5:0] op, input logic z, input vec_t e);
    bus.opcode = op;
    bus.zero = z;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [5:0] rand_op();
    int k = $urandom_range(0, 12);
    logic [5:0] o;
    if (k < 12) return ops[k];
    do begin
      o = 6'($urandom);
    end while (o inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLT, SW, LW, BEQ, BNE, J, HALT});
    return o;
  endfunction

  // force_z < 0 means random zero in the branch-execute cycle.
  task automatic run_instr(input logic [5:0] op, input int force_z);
    logic z;
    for (int s = 0; s < n_steps(op); s++) begin
      z = 1'($urandom);
      if (s == 2 && force_z >= 0) z = force_z[0];
      drive((s == 0) ? rand_op() : op, z, model(op, s, z));
    end
  endtask

  always @(negedge CLK) begin : monitor
    vec_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", dut_vec(), e);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.opcode = ADD;
    bus.zero = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("reset_hold", dut_vec(), '0);
    end
    @(posedge CLK);
    #1;
    Reset = 1'b1;

    run_instr(ADD, -1);
    run_instr(LW, -1);
    run_instr(SW, -1);
    run_instr(BEQ, 1);
    run_instr(BEQ, 0);
    run_instr(BNE, 0);
    run_instr(BNE, 1);
    run_instr(J, -1);
    run_instr(ADDI, -1);
    run_instr(6'b001111, -1);
    for (int i = 0; i < 150; i++) run_instr(rand_op(), -1);

    // Async reset during the SW memory cycle.
    for (int s = 0; s < 3; s++) drive(SW, 1'b0, model(SW, s, 1'b0));
    #1;
    check("sw_mem", dut_vec(), model(SW, 3, 1'b0));
    #1;
    Reset = 1'b0;
    #1;
    check("sw_async_rst", dut_vec(), '0);
    @(posedge CLK);
    #1;
    check("sw_rst_held", dut_vec(), '0);
    Reset = 1'b1;
    run_instr(ORI, -1);

    // HALT parks in decode until reset.
    drive(HALT, 1'b0, model(HALT, 0, 1'b0));
    for (int s = 1; s <= 20; s++) drive(HALT, 1'($urandom), model(HALT, s, 1'b0));
    Reset = 1'b0;
    #1;
    check("halt_rst", dut_vec(), '0);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    run_instr(LW, -1);
    run_instr(J, -1);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
